// File: rtl/vc_plane_receiver_pkg.sv
// Shared constants and flit types for the VC plane receiver, plane controller and router ports.
package vc_plane_receiver_pkg;

    localparam int unsigned VC_N       = 4;
    localparam int unsigned FLIT_W     = 32;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned VC_IDX_W   = $clog2(VC_N);
    localparam int unsigned SEL_W      = VC_N + 1;
    localparam int unsigned OCC_W      = $clog2(FIFO_DEPTH) + 1;

    typedef logic [FLIT_W-1:0]   flit_t;
    typedef logic [VC_IDX_W-1:0] vc_idx_t;

endpackage

// File: rtl/vc_plane_receiver_if.sv
// Flit ingress/egress handshake bundle between a router port and the VC plane receiver.
interface vc_plane_receiver_if
    import vc_plane_receiver_pkg::*;
#(
    parameter int unsigned VC         = VC_N,
    parameter int unsigned DATA_WIDTH = FLIT_W
);
    localparam int unsigned VCW = $clog2(VC);

    logic [DATA_WIDTH-1:0] inData;
    logic [VCW-1:0]        inVC;
    logic                  inValid;
    logic                  inReady;
    logic [DATA_WIDTH-1:0] outData;
    logic [VCW-1:0]        outVC;
    logic                  outValid;
    logic                  outReady;

    modport master (
        output inData, inVC, inValid, outReady,
        input  inReady, outData, outVC, outValid
    );

    modport slave (
        input  inData, inVC, inValid, outReady,
        output inReady, outData, outVC, outValid
    );

endinterface

// File: rtl/vc_plane_fifo.sv
// One VC plane's flit FIFO with occupancy count; storage is not reset.
module vc_plane_fifo
    import vc_plane_receiver_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FLIT_W,
    parameter int unsigned DEPTH      = FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_push,
    input  logic                        i_pop,
    input  logic [DATA_WIDTH-1:0]       i_data,
    output logic [DATA_WIDTH-1:0]       o_data,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(DEPTH):0]      o_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  w_push;
    logic                  w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // Full FIFO never accepts, even when it pops in the same cycle.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vc_plane_receiver.sv
// Per-VC-plane flit buffering with selector-driven egress and selector sequence checking.
module vc_plane_receiver
    import vc_plane_receiver_pkg::*;
#(
    parameter int unsigned VC         = VC_N,
    parameter int unsigned DATA_WIDTH = FLIT_W,
    parameter int unsigned DEPTH      = FIFO_DEPTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [VC:0]                          VCPlaneSelector,
    vc_plane_receiver_if.slave                   bus,
    output logic [VC*($clog2(DEPTH)+1)-1:0]      occupancy,
    output logic                                 seqError
);
    localparam int unsigned VCW = $clog2(VC);
    localparam int unsigned SW  = VC + 1;
    localparam int unsigned CW  = $clog2(DEPTH) + 1;

    logic [1:0]            r_rst_sync;
    logic                  w_rst_n;
    logic [VC-1:0]         w_full;
    logic [VC-1:0]         w_empty;
    logic [VC-1:0]         w_push;
    logic [VC-1:0]         w_pop;
    logic [DATA_WIDTH-1:0] w_head [VC];
    logic                  w_sel_ok;
    logic [VCW-1:0]        w_sel_idx;
    logic [SW-1:0]         r_prev_sel;
    logic                  r_prev_vld;
    logic                  r_seq_err;
    logic [SW-1:0]         w_prev_inc;
    logic                  w_seq_bad;

    // Assert immediately, release two edges later so all state leaves reset together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    for (genvar p = 0; p < VC; p++) begin : g_plane
        assign w_push[p] = bus.inValid && bus.inReady && (bus.inVC == VCW'(p));
        assign w_pop[p]  = bus.outValid && bus.outReady && (VCPlaneSelector == SW'(p));

        vc_plane_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (w_rst_n),
            .i_push  (w_push[p]),
            .i_pop   (w_pop[p]),
            .i_data  (bus.inData),
            .o_data  (w_head[p]),
            .o_full  (w_full[p]),
            .o_empty (w_empty[p]),
            .o_count (occupancy[p*CW +: CW])
        );
    end

    assign bus.inReady = !w_full[bus.inVC];

    assign w_sel_ok     = (VCPlaneSelector < SW'(VC));
    assign w_sel_idx    = VCW'(VCPlaneSelector);
    assign bus.outValid = w_sel_ok && !w_empty[w_sel_idx];
    assign bus.outData  = w_head[w_sel_idx];
    assign bus.outVC    = w_sel_idx;

    // Legal selector moves: hold, or advance by one with wrap at VC.
    assign w_prev_inc = (r_prev_sel == SW'(VC - 1)) ? '0 : r_prev_sel + 1'b1;
    assign w_seq_bad  = !w_sel_ok
                     || (r_prev_vld && (VCPlaneSelector != r_prev_sel)
                                    && (VCPlaneSelector != w_prev_inc));

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_prev_sel <= '0;
            r_prev_vld <= 1'b0;
            r_seq_err  <= 1'b0;
        end else begin
            r_prev_sel <= VCPlaneSelector;
            r_prev_vld <= 1'b1;
            if (w_seq_bad) begin
                r_seq_err <= 1'b1;
            end
        end
    end

    assign seqError = r_seq_err;

endmodule

// File: tb/tb_vc_plane_receiver.sv
// Self-checking bench for vc_plane_receiver: vector table, corner sequences and a queue scoreboard.
module tb_vc_plane_receiver;
    import vc_plane_receiver_pkg::*;

    localparam int VC    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int SW    = VC + 1;
    localparam int VW    = $clog2(VC);
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int OW    = VC * CW;

    typedef struct {
        logic [SW-1:0] sel;
        logic          iv;
        logic [VW-1:0] ivc;
        logic [DW-1:0] d;
        logic          ordy;
        logic          e_rdy;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic [OW-1:0] e_occ;
    } vec_t;

    logic          clk;
    logic          rst = 1'b1;
    logic [SW-1:0] sel;
    logic [OW-1:0] occ;
    logic          seq_err;

    vc_plane_receiver_if #(.VC(VC), .DATA_WIDTH(DW)) bus ();

    vc_plane_receiver #(.VC(VC), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .VCPlaneSelector (sel),
        .bus             (bus),
        .occupancy       (occ),
        .seqError        (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    logic [DW-1:0] sbq [VC][$];
    bit            m_armed;
    int            m_prev;
    bit            m_err;
    logic          m_rdy;
    logic          m_ov;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [OW-1:0] model_occ();
        logic [OW-1:0] e;
        e = '0;
        for (int p = 0; p < VC; p++) e[p*CW +: CW] = CW'(sbq[p].size());
        return e;
    endfunction

    // Drive one cycle's inputs and compare every output against the scoreboard.
    task automatic drive_and_check(input logic [SW-1:0] s_i, input logic iv, input logic [VW-1:0] ivc,
                                   input logic [DW-1:0] d, input logic ordy);
        int s;
        sel = s_i; bus.inValid = iv; bus.inVC = ivc; bus.inData = d; bus.outReady = ordy;
        #1;
        s     = int'(s_i);
        m_rdy = (sbq[int'(ivc)].size() < DEPTH);
        m_ov  = (s < VC) && (sbq[s % VC].size() > 0) && (s < VC);
        check("inReady", 64'(bus.inReady), 64'(m_rdy));
        check("outValid", 64'(bus.outValid), 64'(m_ov));
        if (m_ov) begin
            check("outData", 64'(bus.outData), 64'(sbq[s][0]));
            check("outVC", 64'(bus.outVC), 64'(s));
        end
        check("occupancy", 64'(occ), 64'(model_occ()));
        check("seqError", 64'(seq_err), 64'(m_err));
    endtask

    task automatic advance();
        int   s;
        int   inc;
        logic do_push;
        logic do_pop;
        s       = int'(sel);
        do_push = bus.inValid && m_rdy;
        do_pop  = m_ov && bus.outReady;
        @(posedge clk);
        if (do_pop) void'(sbq[s].pop_front());
        if (do_push) sbq[int'(bus.inVC)].push_back(bus.inData);
        inc = (m_prev == VC - 1) ? 0 : m_prev + 1;
        if (s >= VC) m_err = 1'b1;
        else if (m_armed && s != m_prev && s != inc) m_err = 1'b1;
        m_prev  = s;
        m_armed = 1'b1;
        #1;
    endtask

    task automatic step(input int s_i, input int iv, input int ivc, input int d, input int ordy);
        drive_and_check(SW'(s_i), 1'(iv), VW'(ivc), DW'(d), 1'(ordy));
        advance();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.inValid = 1'b0; bus.inVC = '0; bus.inData = '0; bus.outReady = 1'b0;
        #1;
        check("rst_outValid", 64'(bus.outValid), 64'(0));
        check("rst_occupancy", 64'(occ), 64'(0));
        check("rst_inReady", 64'(bus.inReady), 64'(1));
        check("rst_seqError", 64'(seq_err), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        sel = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int p = 0; p < VC; p++) sbq[p].delete();
        m_prev = 0; m_armed = 1'b1; m_err = 1'b0;
    endtask

    function automatic vec_t mk(int s_i, int iv, int ivc, int d, int ordy,
                                int rdy, int ov, int od, int occ_i);
        vec_t v;
        v.sel = SW'(s_i); v.iv = 1'(iv); v.ivc = VW'(ivc); v.d = DW'(d); v.ordy = 1'(ordy);
        v.e_rdy = 1'(rdy); v.e_ov = 1'(ov); v.e_od = DW'(od); v.e_occ = OW'(occ_i);
        return v;
    endfunction

    vec_t vt[17];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cur;
        sel = '0;
        bus.inValid = 1'b0; bus.inVC = '0; bus.inData = '0; bus.outReady = 1'b0;
        #2;
        do_reset();

        // Selector sweep with one flit to plane 2, then plane 1 fill/overflow and ordered drain.
        vt[0]  = mk(0, 1, 2, 'hA0, 1, 1, 0, 0,     'h000);
        vt[1]  = mk(1, 0, 0, 0,    1, 1, 0, 0,     'h040);
        vt[2]  = mk(2, 0, 0, 0,    1, 1, 1, 'hA0,  'h040);
        vt[3]  = mk(3, 0, 0, 0,    1, 1, 0, 0,     'h000);
        vt[4]  = mk(0, 1, 1, 'hB0, 1, 1, 0, 0,     'h000);
        vt[5]  = mk(0, 1, 1, 'hB1, 1, 1, 0, 0,     'h008);
        vt[6]  = mk(0, 1, 1, 'hB2, 1, 1, 0, 0,     'h010);
        vt[7]  = mk(0, 1, 1, 'hB3, 1, 1, 0, 0,     'h018);
        vt[8]  = mk(0, 1, 1, 'hB4, 1, 0, 0, 0,     'h020);
        vt[9]  = mk(0, 1, 0, 'hC0, 0, 1, 0, 0,     'h020);
        vt[10] = mk(0, 0, 0, 0,    0, 1, 1, 'hC0,  'h021);
        vt[11] = mk(0, 0, 0, 0,    1, 1, 1, 'hC0,  'h021);
        vt[12] = mk(1, 0, 0, 0,    1, 1, 1, 'hB0,  'h020);
        vt[13] = mk(1, 0, 0, 0,    1, 1, 1, 'hB1,  'h018);
        vt[14] = mk(1, 0, 0, 0,    1, 1, 1, 'hB2,  'h010);
        vt[15] = mk(1, 0, 0, 0,    1, 1, 1, 'hB3,  'h008);
        vt[16] = mk(1, 0, 0, 0,    1, 1, 0, 0,     'h000);
        for (int i = 0; i < 17; i++) begin
            drive_and_check(vt[i].sel, vt[i].iv, vt[i].ivc, vt[i].d, vt[i].ordy);
            check($sformatf("v%0d_inReady", i), 64'(bus.inReady), 64'(vt[i].e_rdy));
            check($sformatf("v%0d_outValid", i), 64'(bus.outValid), 64'(vt[i].e_ov));
            if (vt[i].e_ov) check($sformatf("v%0d_outData", i), 64'(bus.outData), 64'(vt[i].e_od));
            check($sformatf("v%0d_occupancy", i), 64'(occ), 64'(vt[i].e_occ));
            advance();
        end

        // Plane 3 full while selected and popping: no push, one pop, space next cycle.
        for (int k = 0; k < 4; k++) step(1, 1, 3, 'hD0 + k, 0);
        step(2, 0, 0, 0, 0);
        drive_and_check(SW'(3), 1'b1, VW'(3), DW'('hDF), 1'b1);
        check("full_inReady", 64'(bus.inReady), 64'(0));
        check("full_outData", 64'(bus.outData), 64'('hD0));
        check("full_occ3", 64'(occ[3*CW +: CW]), 64'(4));
        advance();
        drive_and_check(SW'(3), 1'b0, VW'(3), DW'(0), 1'b0);
        check("after_pop_occ3", 64'(occ[3*CW +: CW]), 64'(3));
        check("after_pop_inReady", 64'(bus.inReady), 64'(1));
        advance();
        for (int k = 0; k < 3; k++) step(3, 0, 0, 0, 1);

        // Back-pressure on plane 0: head holds, then drains in order.
        step(3, 1, 0, 'hE0, 1);
        step(3, 1, 0, 'hE1, 1);
        for (int k = 0; k < 3; k++) begin
            drive_and_check(SW'(0), 1'b0, VW'(0), DW'(0), 1'b0);
            check("stall_outData", 64'(bus.outData), 64'('hE0));
            check("stall_occ0", 64'(occ[CW-1:0]), 64'(2));
            advance();
        end
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        drive_and_check(SW'(0), 1'b0, VW'(0), DW'(0), 1'b0);
        check("drained_occ0", 64'(occ[CW-1:0]), 64'(0));
        advance();

        // Selector skip 1 -> 3 sets seqError; out-of-range selector neither shows nor pops.
        step(1, 1, 1, 'hF0, 0);
        step(3, 0, 0, 0, 0);
        drive_and_check(SW'(3), 1'b0, VW'(0), DW'(0), 1'b0);
        check("seq_skip_err", 64'(seq_err), 64'(1));
        advance();
        drive_and_check(SW'(5), 1'b0, VW'(0), DW'(0), 1'b1);
        check("sel5_outValid", 64'(bus.outValid), 64'(0));
        check("sel5_seqError", 64'(seq_err), 64'(1));
        advance();
        drive_and_check(SW'(5), 1'b0, VW'(0), DW'(0), 1'b1);
        check("sel5_no_pop_occ1", 64'(occ[CW +: CW]), 64'(1));
        advance();
        do_reset();

        // Load occupancy {1,2,3,4}, then reset mid-stream.
        for (int p = 0; p < VC; p++)
            for (int k = 0; k <= p; k++) step(0, 1, p, 'h100 + p * 16 + k, 0);
        drive_and_check(SW'(0), 1'b0, VW'(0), DW'(0), 1'b0);
        check("preload_occ", 64'(occ), 64'('h8D1));
        do_reset();
        for (int s = 0; s < VC; s++) step(s, 0, 0, 0, 1);

        // Random traffic with a legal selector walk.
        cur = VC - 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) cur = (cur == VC - 1) ? 0 : cur + 1;
            step(cur, int'($urandom_range(0, 1)), int'($urandom_range(0, VC - 1)),
                 int'($urandom), int'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
